// File: rtl/key_press_conditioner.sv
// ---------------------------------------------------------------------------
// key_press_conditioner
//
// Turns one raw active-low pushbutton into a clean single-cycle press pulse
// for the tug-of-war game logic (one instance per player). The raw key is
// synchronised, debounced with a consecutive-sample counter and converted
// into exactly one pulse per physical press. Holding the key never produces
// repeat pulses.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive equal synchronised samples needed to accept
//                     a change of the debounced level (>= 2)
//   CNT_W           - debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk    in  system clock (divided game clock)
//   reset  in  asynchronous, active-low reset
//   key_n  in  raw button, 0 = pressed, 1 = released, asynchronous to clk
//   en     in  1 = press pulses allowed, 0 = pulses suppressed (tracking
//              continues)
//   press  out one-cycle pulse marking an accepted press (registered)
//   held   out debounced level, 1 while an accepted press is in progress
//              (registered)
// ---------------------------------------------------------------------------
module key_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic en,
  output logic press,
  output logic held
);

  localparam int              SYNC_STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. Flops reset to 1 (released) so a key already held
  // low when reset lifts is seen as a fresh falling edge and fully debounced.
  // Only the last stage is used by the FSM.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_key;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_n};
    end
  end

  assign sync_key = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept_next = 1'b0;
    unique case (state_reg)
      RELEASED: begin
        if (!sync_key) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync_key) begin
          // Low run too short: treat as a glitch.
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = PRESSED;
          cnt_next    = '0;
          accept_next = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync_key) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!sync_key) begin
          // Bounce while releasing: still the same press, no new pulse.
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Both outputs lag the FSM state by one register so that press and
  // held rise on the same edge. en is sampled on the accept edge itself; a
  // press accepted while en=0 is simply dropped, it is never replayed later.
  // -------------------------------------------------------------------------
  logic accept_reg;
  logic press_reg;
  logic held_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_reg <= 1'b0;
      press_reg  <= 1'b0;
      held_reg   <= 1'b0;
    end else begin
      accept_reg <= accept_next & en;
      press_reg  <= accept_reg;
      held_reg   <= (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);
    end
  end

  assign press = press_reg;
  assign held  = held_reg;

endmodule

// File: tb/tb_key_press_conditioner.sv
module tb_key_press_conditioner;

  localparam int D   = 4;     // debounce samples
  localparam int LAT = D + 2; // edges from first captured change to output

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic en;
  logic press;
  logic held;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int press_seen = 0;
  int held_seen  = 0;
  bit cmp_en = 1'b0;

  key_press_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .en    (en),
    .press (press),
    .held  (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (cmp_en) begin
      press_seen <= press_seen + (press === 1'b1 ? 1 : 0);
      held_seen  <= held_seen  + (held  === 1'b1 ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", name, act, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural reference: keep a history of raw key values seen at each
  // edge. The synchronised sample the debouncer looks at is two edges old.
  // The debounced level flips once the most recent D synchronised samples
  // all disagree with it. Outputs appear one edge after that decision;
  // a pulse is produced only for a 0->1 flip with en=1 on the decision edge.
  // -------------------------------------------------------------------------
  logic [D:0] key_hist;   // bit 0 = key captured at the latest edge
  logic       m_level;
  logic       m_pend;
  logic       exp_press;
  logic       exp_held;
  logic       win_low;
  logic       win_high;

  always_comb begin
    win_low  = (key_hist[D:1] == '0);
    win_high = (&key_hist[D:1]);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_hist  <= '1;
      m_level   <= 1'b0;
      m_pend    <= 1'b0;
      exp_press <= 1'b0;
      exp_held  <= 1'b0;
    end else begin
      exp_held  <= m_level;
      exp_press <= m_pend;
      m_pend    <= !m_level && win_low && en;
      if (!m_level && win_low)      m_level <= 1'b1;
      else if (m_level && win_high) m_level <= 1'b0;
      key_hist  <= {key_hist[D-1:0], key_n};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks = checks + 2;
      if (press !== exp_press) begin
        failures = failures + 1;
        $display("FAIL model_press actual=%0d expected=%0d t=%0t", press, exp_press, $time);
      end
      if (held !== exp_held) begin
        failures = failures + 1;
        $display("FAIL model_held actual=%0d expected=%0d t=%0t", held, exp_held, $time);
      end
    end
  end

  // Wait (bounded) for press/held to reach a level; returns the edge number
  // of the posedge that produced it, or -1000 on timeout.
  task automatic wait_level(input bit use_held, input bit lvl, output int at_edge);
    at_edge = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((use_held ? held : press) === lvl) begin
        at_edge = edge_cnt;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e0, at, p0, h0;

  initial begin
    reset = 1'b1;
    key_n = 1'b0;
    en    = 1'b1;

    // ---- 1: reset while key held, release reset while still holding ----
    #2 reset = 1'b0;
    #1;
    check("rst_press", press, 0);
    check("rst_held", held, 0);
    cmp_en = 1'b1;
    idle(2);
    reset = 1'b1;
    e0 = edge_cnt + 1;
    p0 = press_seen;
    wait_level(1'b0, 1'b1, at);
    check("rst_hold_latency", at - e0, LAT);
    check("model_rise_pin", exp_press, 1);
    idle(20);
    check("rst_hold_one_pulse", press_seen - p0, 1);
    key_n = 1'b1;
    idle(15);

    // ---- 2: short low pulse (3 samples) is rejected ----
    p0 = press_seen; h0 = held_seen;
    key_n = 1'b0; idle(3); key_n = 1'b1; idle(15);
    check("glitch_press", press_seen - p0, 0);
    check("glitch_held", held_seen - h0, 0);

    // boundary: exactly D samples low is accepted
    p0 = press_seen;
    key_n = 1'b0; idle(D); key_n = 1'b1; idle(20);
    check("exact_d_press", press_seen - p0, 1);

    // ---- 3: long hold, latency and single pulse ----
    p0 = press_seen;
    key_n = 1'b0;
    e0 = edge_cnt + 1;
    wait_level(1'b0, 1'b1, at);
    check("hold_press_latency", at - e0, LAT);
    check("hold_held_at_rise", held, 1);
    @(negedge clk);
    check("hold_press_width", press, 0);
    idle(100 - (edge_cnt - e0) - 1);
    check("hold_one_pulse", press_seen - p0, 1);
    check("hold_held_level", held, 1);
    key_n = 1'b1;
    e0 = edge_cnt + 1;
    wait_level(1'b1, 1'b0, at);
    check("release_latency", at - e0, LAT);
    idle(10);

    // ---- 4: bounce on release ----
    p0 = press_seen;
    key_n = 1'b0; idle(10);
    check("bounce_held_before", held, 1);
    h0 = held_seen;
    key_n = 1'b1; idle(2);
    key_n = 1'b0; idle(10);
    check("bounce_held_through", held_seen - h0, 12);
    key_n = 1'b1; idle(20);
    check("bounce_one_pulse", press_seen - p0, 1);
    check("bounce_held_end", held, 0);

    // ---- 5: en low across the accept edge ----
    p0 = press_seen;
    en = 1'b0; key_n = 1'b0;
    idle(8);
    check("en_off_held", held, 1);
    en = 1'b1;
    idle(20);
    check("en_off_no_pulse", press_seen - p0, 0);
    check("en_off_held_late", held, 1);
    key_n = 1'b1; idle(12);
    p0 = press_seen;
    key_n = 1'b0; idle(12); key_n = 1'b1; idle(12);
    check("en_on_next_press", press_seen - p0, 1);

    // ---- 6: reset during release debounce ----
    key_n = 1'b0; idle(10);
    key_n = 1'b1; idle(4);
    check("rw_held_before_rst", held, 1);
    #2 reset = 1'b0;
    #1;
    check("rw_rst_held", held, 0);
    check("rw_rst_press", press, 0);
    @(negedge clk);
    reset = 1'b1;
    p0 = press_seen; h0 = held_seen;
    idle(15);
    check("rw_after_rst_press", press_seen - p0, 0);
    check("rw_after_rst_held", held_seen - h0, 0);

    // ---- random phase: runs of random length, random en, rare resets ----
    for (int seg = 0; seg < 350; seg++) begin
      key_n = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        #1;
        check("rand_rst_held", held, 0);
        check("rand_rst_press", press, 0);
        @(negedge clk);
        reset = 1'b1;
      end
      idle($urandom_range(1, 12));
    end
    key_n = 1'b1;
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
